// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus layouts, mem_ctl fields,
// size codes, FSM states and alignment helpers.
package mem_stage_pkg;

    localparam int EX2MEM_W   = 108;
    localparam int MEM2WB_W   = 70;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    // mem_ctl bit positions
    localparam int CTL_LD  = 5;
    localparam int CTL_ST  = 4;
    localparam int CTL_UNS = 1;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0]            mem_ctl;
        logic [REG_W-1:0]      st_data;
        logic [REG_W-1:0]      exe_result;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  rd_we;
        logic [REG_W-1:0]      pc;
    } ex2mem_t;

    typedef struct packed {
        logic [REG_W-1:0]      wb_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  rd_we;
        logic [REG_W-1:0]      pc;
    } mem2wb_t;

    // load and store together is illegal and decodes as neither
    function automatic logic is_load(input logic [5:0] ctl);
        return ctl[CTL_LD] & ~ctl[CTL_ST];
    endfunction

    function automatic logic is_store(input logic [5:0] ctl);
        return ctl[CTL_ST] & ~ctl[CTL_LD];
    endfunction

    // size 2'b11 is treated as a word everywhere
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == SZ_H) & a[0]) | (size[1] & (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational store strobe/data alignment and load extraction/extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  a,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [15:0] sh;

    always_comb begin
        sh      = 16'(rdata >> {a, 3'b000});
        wstrb   = 4'b0000;
        wdata   = '0;
        ld_data = '0;
        case (size)
            SZ_B: begin
                wstrb   = 4'b0001 << a;
                wdata   = {4{st_data[7:0]}};
                ld_data = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                wstrb   = a[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{st_data[15:0]}};
                ld_data = uns ? {16'b0, sh} : {{16{sh[15]}}, sh};
            end
            default: begin
                wstrb   = 4'b1111;
                wdata   = st_data;
                ld_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX->MEM bus, runs the data-memory handshake
// and hands results to WB. Optional misalignment trap under MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [EX2MEM_W-1:0]  ex2mem_bus_i,
    input  logic                 ctl_ex_over_i,
    output logic                 ctl_mem_allowin_o,
    input  logic                 ctl_wb_allowin_i,
    output logic                 ctl_mem_over_o,
    output logic [MEM2WB_W-1:0]  mem2wb_bus_o,
    output logic [4:0]           ctl_mem_dest_o,
    output logic                 data_req_o,
    output logic                 data_wr_o,
    output logic [1:0]           data_size_o,
    output logic [3:0]           data_wstrb_o,
    output logic [31:0]          data_addr_o,
    output logic [31:0]          data_wdata_o,
    input  logic                 data_addr_ok_i,
    input  logic                 data_data_ok_i,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                 ctl_mem_ale_o,
`endif
    input  logic [31:0]          data_rdata_i
);

    ex2mem_t     bus_in, bus_q;
    mem2wb_t     wb;
    state_t      state, state_nx;
    logic        valid;
    logic [31:0] rdata_q;

    logic        ld, st, mem_in, mis_in, mis_q;
    logic        latch, handoff;
    logic [1:0]  size, a;
    logic [3:0]  wstrb;
    logic [31:0] wdata, ld_data, req_addr;
    logic        unused;

    assign bus_in = ex2mem_bus_i;
    assign ld     = is_load(bus_q.mem_ctl);
    assign st     = is_store(bus_q.mem_ctl);
    assign size   = bus_q.mem_ctl[3:2];
    assign a      = bus_q.exe_result[1:0];
    assign mem_in = is_load(bus_in.mem_ctl) | is_store(bus_in.mem_ctl);
    assign unused = bus_q.mem_ctl[0];

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_in = mem_in & is_misaligned(bus_in.mem_ctl[3:2], bus_in.exe_result[1:0]);
    assign mis_q  = (ld | st) & is_misaligned(size, a);
    assign ctl_mem_ale_o = ctl_mem_over_o & mis_q;
    assign req_addr = bus_q.exe_result;
`else
    assign mis_in = 1'b0;
    assign mis_q  = 1'b0;
    // without the check, the low address bits are simply forced to the access size
    assign req_addr = size[1]       ? {bus_q.exe_result[31:2], 2'b00} :
                      (size == SZ_H) ? {bus_q.exe_result[31:1], 1'b0}  :
                                       bus_q.exe_result;
`endif

    assign ctl_mem_over_o    = valid & (state == S_DONE);
    assign ctl_mem_allowin_o = ~valid | (ctl_mem_over_o & ctl_wb_allowin_i);
    assign latch             = ctl_ex_over_i & ctl_mem_allowin_o;
    assign handoff           = ctl_mem_over_o & ctl_wb_allowin_i;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        data_req_o = 1'b0;
        if (latch) begin
            state_nx = (mem_in & ~mis_in) ? S_REQ : S_DONE;
        end else begin
            case (state)
                S_REQ:   if (data_addr_ok_i) state_nx = S_WAIT;
                S_WAIT:  if (data_data_ok_i) state_nx = S_DONE;
                S_DONE:  if (handoff)        state_nx = S_IDLE;
                default: state_nx = state;
            endcase
        end
        if (state == S_REQ) data_req_o = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            bus_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (latch) begin
                bus_q <= bus_in;
                valid <= 1'b1;
            end else if (handoff) begin
                valid <= 1'b0;
            end
            if (state == S_WAIT && data_data_ok_i) rdata_q <= data_rdata_i;
        end
    end

    mem_align u_align (
        .size    (size),
        .uns     (bus_q.mem_ctl[CTL_UNS]),
        .a       (a),
        .st_data (bus_q.st_data),
        .rdata   (rdata_q),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .ld_data (ld_data)
    );

    // request fields read zero outside REQ so reset and idle look identical
    assign data_wr_o    = data_req_o & st;
    assign data_size_o  = data_req_o ? size : 2'b00;
    assign data_addr_o  = data_req_o ? req_addr : '0;
    assign data_wstrb_o = data_wr_o ? wstrb : 4'b0000;
    assign data_wdata_o = data_wr_o ? wdata : '0;

    assign wb.wb_data   = (ld & ~mis_q) ? ld_data : bus_q.exe_result;
    assign wb.rd_addr   = bus_q.rd_addr;
    assign wb.rd_we     = bus_q.rd_we & ~mis_q;
    assign wb.pc        = bus_q.pc;
    assign mem2wb_bus_o = wb;

    assign ctl_mem_dest_o = valid ? bus_q.rd_addr : 5'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Scenario bench for mem_stage: scoreboard of expected WB bus values plus
// inline handshake/timing checks per scenario.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [107:0] ex_bus = '0;
    logic         ex_over = 1'b0;
    logic         mem_allowin;
    logic         wb_allowin = 1'b0;
    logic         over;
    logic [69:0]  wb_bus;
    logic [4:0]   dest;
    logic         req, wr;
    logic [1:0]   size;
    logic [3:0]   wstrb;
    logic [31:0]  addr, wdata;
    logic         addr_ok = 1'b0;
    logic         data_ok = 1'b0;
    logic [31:0]  rdata = '0;
`ifdef MEM_ALIGN_CHECK_EN
    logic         ale;
`endif

    int checks = 0;
    int failures = 0;
    logic [69:0] exp_q[$];
    logic [69:0] sb_e;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex2mem_bus_i      (ex_bus),
        .ctl_ex_over_i     (ex_over),
        .ctl_mem_allowin_o (mem_allowin),
        .ctl_wb_allowin_i  (wb_allowin),
        .ctl_mem_over_o    (over),
        .mem2wb_bus_o      (wb_bus),
        .ctl_mem_dest_o    (dest),
        .data_req_o        (req),
        .data_wr_o         (wr),
        .data_size_o       (size),
        .data_wstrb_o      (wstrb),
        .data_addr_o       (addr),
        .data_wdata_o      (wdata),
        .data_addr_ok_i    (addr_ok),
        .data_data_ok_i    (data_ok),
`ifdef MEM_ALIGN_CHECK_EN
        .ctl_mem_ale_o     (ale),
`endif
        .data_rdata_i      (rdata)
    );

    function automatic logic [107:0] mk_ex(input logic [5:0] c, input logic [31:0] sd,
                                           input logic [31:0] r, input logic [4:0] rd,
                                           input logic we, input logic [31:0] pc);
        return {c, sd, r, rd, we, pc};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] d, input logic [4:0] rd,
                                          input logic we, input logic [31:0] pc);
        return {d, rd, we, pc};
    endfunction

    // every WB handoff is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst_n && over && wb_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h required=none", wb_bus);
            end else begin
                sb_e = exp_q.pop_front();
                if (wb_bus !== sb_e) begin
                    failures++;
                    $display("FAIL sb_bus got=%h required=%h", wb_bus, sb_e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_allowin !== 1'b1) begin failures++; $display("FAIL rst_allowin got=%b required=1", mem_allowin); end
        checks++;
        if ({over, req, wr, size, wstrb, addr, wdata} !== '0) begin
            failures++; $display("FAIL rst_outputs got=%b%b%b", over, req, wr);
        end
        checks++;
        if ({wb_bus, dest} !== '0) begin failures++; $display("FAIL rst_bus got=%h/%h required=0", wb_bus, dest); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu;
        ex_bus = mk_ex(6'b000000, 32'hDEAD_BEEF, 32'h1234, 5'd5, 1'b1, 32'h100);
        ex_over = 1'b1;
        wb_allowin = 1'b1;
        exp_q.push_back(mk_wb(32'h1234, 5'd5, 1'b1, 32'h100));
        tick();
        ex_over = 1'b0;
        checks++;
        if (over !== 1'b1 || req !== 1'b0) begin failures++; $display("FAIL alu_over got=%b req=%b required=1/0", over, req); end
        checks++;
        if (dest !== 5'd5) begin failures++; $display("FAIL alu_dest got=%0d required=5", dest); end
        tick();
        checks++;
        if (over !== 1'b0 || dest !== 5'd0) begin failures++; $display("FAIL alu_clear got=%b/%0d required=0/0", over, dest); end
    endtask

    task automatic test_load(input logic [5:0] c, input logic [31:0] a, input logic [31:0] rd_val,
                             input logic [31:0] exp_d, input int stall, input logic [31:0] exp_addr);
        ex_bus = mk_ex(c, 32'h0, a, 5'd7, 1'b1, 32'h200);
        ex_over = 1'b1;
        addr_ok = 1'b1;
        wb_allowin = 1'b1;
        exp_q.push_back(mk_wb(exp_d, 5'd7, 1'b1, 32'h200));
        tick();
        ex_over = 1'b0;
        checks++;
        if ({req, wr, wstrb, size, addr} !== {1'b1, 1'b0, 4'b0000, c[3:2], exp_addr}) begin
            failures++; $display("FAIL ld_req got=%b/%b/%b/%h required=1/0/0000/%h", req, wr, wstrb, addr, exp_addr);
        end
        tick();
        addr_ok = 1'b0;
        checks++;
        if (req !== 1'b0 || over !== 1'b0) begin failures++; $display("FAIL ld_wait got=%b/%b required=0/0", req, over); end
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (over !== 1'b0) begin failures++; $display("FAIL ld_stall got=%b required=0", over); end
        end
        data_ok = 1'b1;
        rdata = rd_val;
        tick();
        data_ok = 1'b0;
        rdata = 32'h5555_5555;
        checks++;
        if (over !== 1'b1) begin failures++; $display("FAIL ld_over got=%b required=1", over); end
        tick();
        checks++;
        if (over !== 1'b0) begin failures++; $display("FAIL ld_done got=%b required=0", over); end
    endtask

    task automatic test_store_stall;
        ex_bus = mk_ex(6'b010100, 32'hABCD_1234, 32'h2002, 5'd0, 1'b0, 32'h300);
        ex_over = 1'b1;
        addr_ok = 1'b0;
        wb_allowin = 1'b1;
        exp_q.push_back(mk_wb(32'h2002, 5'd0, 1'b0, 32'h300));
        tick();
        ex_over = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) addr_ok = 1'b1;
            checks++;
            if ({req, wr, size, wstrb, addr, wdata, over} !==
                {1'b1, 1'b1, 2'b01, 4'b1100, 32'h2002, 32'h1234_1234, 1'b0}) begin
                failures++;
                $display("FAIL sth_req cyc=%0d got=%b%b %b %b %h %h over=%b required=11 01 1100 2002 12341234 0",
                         i, req, wr, size, wstrb, addr, wdata, over);
            end
            tick();
        end
        addr_ok = 1'b0;
        data_ok = 1'b1;
        tick();
        data_ok = 1'b0;
        checks++;
        if (over !== 1'b1) begin failures++; $display("FAIL sth_over got=%b required=1", over); end
        tick();
        // byte store at the top lane
        ex_bus = mk_ex(6'b010000, 32'h0000_005A, 32'h2003, 5'd0, 1'b0, 32'h304);
        ex_over = 1'b1;
        addr_ok = 1'b1;
        exp_q.push_back(mk_wb(32'h2003, 5'd0, 1'b0, 32'h304));
        tick();
        ex_over = 1'b0;
        checks++;
        if ({wstrb, wdata, size} !== {4'b1000, 32'h5A5A_5A5A, 2'b00}) begin
            failures++; $display("FAIL stb_lane got=%b %h required=1000 5a5a5a5a", wstrb, wdata);
        end
        tick();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        tick();
        data_ok = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        ex_bus = mk_ex(6'b000000, 32'h0, 32'hAAAA_0001, 5'd3, 1'b1, 32'h400);
        ex_over = 1'b1;
        wb_allowin = 1'b0;
        exp_q.push_back(mk_wb(32'hAAAA_0001, 5'd3, 1'b1, 32'h400));
        tick();
        ex_bus = mk_ex(6'b000000, 32'h0, 32'hBBBB_0002, 5'd4, 1'b1, 32'h404);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({over, mem_allowin, wb_bus} !== {1'b1, 1'b0, mk_wb(32'hAAAA_0001, 5'd3, 1'b1, 32'h400)}) begin
                failures++; $display("FAIL bp_hold cyc=%0d over=%b allowin=%b bus=%h", i, over, mem_allowin, wb_bus);
            end
            tick();
        end
        wb_allowin = 1'b1;
        exp_q.push_back(mk_wb(32'hBBBB_0002, 5'd4, 1'b1, 32'h404));
        #1;
        checks++;
        if (mem_allowin !== 1'b1) begin failures++; $display("FAIL bp_release got=%b required=1", mem_allowin); end
        tick();
        ex_over = 1'b0;
        checks++;
        if (over !== 1'b1 || dest !== 5'd4) begin failures++; $display("FAIL b2b_next got=%b/%0d required=1/4", over, dest); end
        tick();
        checks++;
        if (over !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b required=0", over); end
    endtask

    task automatic test_reset_mid;
        ex_bus = mk_ex(6'b101000, 32'h0, 32'h4000, 5'd8, 1'b1, 32'h500);
        ex_over = 1'b1;
        addr_ok = 1'b1;
        tick();
        ex_over = 1'b0;
        tick();
        addr_ok = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({req, over, mem_allowin} !== 3'b001) begin
            failures++; $display("FAIL rstmid got=%b%b%b required=001", req, over, mem_allowin);
        end
        rst_n = 1'b1;
        data_ok = 1'b1;
        rdata = 32'h1111_2222;
        tick();
        data_ok = 1'b0;
        tick();
        checks++;
        if ({req, over, mem_allowin, dest} !== {3'b001, 5'd0}) begin
            failures++; $display("FAIL late_dok got=%b%b%b dest=%0d required=001 0", req, over, mem_allowin, dest);
        end
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_misalign;
        ex_bus = mk_ex(6'b101000, 32'h0, 32'h3001, 5'd9, 1'b1, 32'h600);
        ex_over = 1'b1;
        addr_ok = 1'b1;
        wb_allowin = 1'b1;
        exp_q.push_back(mk_wb(32'h3001, 5'd9, 1'b0, 32'h600));
        tick();
        ex_over = 1'b0;
        addr_ok = 1'b0;
        checks++;
        if ({req, over, ale} !== 3'b011) begin failures++; $display("FAIL ale got=%b%b%b required=011", req, over, ale); end
        tick();
        checks++;
        if (ale !== 1'b0) begin failures++; $display("FAIL ale_clear got=%b required=0", ale); end
    endtask
`else
    task automatic test_misalign;
        test_load(6'b101000, 32'h3001, 32'h1122_3344, 32'h1122_3344, 0, 32'h3000);
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load(6'b100000, 32'h1003, 32'h80FF_FF7F, 32'hFFFF_FF80, 0, 32'h1003);
        test_load(6'b100110, 32'h1002, 32'h8234_5678, 32'h0000_8234, 2, 32'h1002);
        test_store_stall();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
